// File: rtl/softmax_argmax.sv
// softmax_argmax: classifier stage behind softmax. Collects one frame of N
// (probability, index) elements and reports the winning class index, its
// probability, the saturated frame sum and integrity flags.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   x, x_i, i_valid element stream from softmax; o_rdy accepts it
//   o_valid, i_rdy  result handshake towards downstream
//   y_class/y_prob  index and value of the maximum element
//   y_sum           frame sum saturated to DW bits
//   y_err           {negative element, sum off 1.0 by more than TOL, index out of sequence}
module softmax_argmax #(
  parameter int N    = 10,
  parameter int IW   = 4,
  parameter int DW   = 32,
  parameter int FRAC = 15,
  parameter int TOL  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] x,
  input  logic        [IW-1:0] x_i,
  input  logic                 i_valid,
  input  logic                 i_rdy,
  output logic                 o_rdy,
  output logic                 o_valid,
  output logic        [IW-1:0] y_class,
  output logic signed [DW-1:0] y_prob,
  output logic signed [DW-1:0] y_sum,
  output logic        [2:0]    y_err
);

  localparam int AW = DW + IW;

  typedef enum logic {ACC, OUT} state_t;

  state_t               r_state;
  logic        [IW-1:0] r_cnt;
  logic        [IW-1:0] r_max_i;
  logic signed [DW-1:0] r_max;
  logic signed [AW-1:0] r_acc;
  logic                 r_seq_err;
  logic                 r_neg_err;

  logic                 w_take;
  logic                 w_last;
  logic                 w_upd;
  logic signed [AW-1:0] w_acc_nx;
  logic signed [DW-1:0] w_max_nx;
  logic        [IW-1:0] w_max_i_nx;
  logic                 w_seq_nx;
  logic                 w_neg_nx;
  logic signed [AW:0]   w_dev;
  logic signed [AW:0]   w_dev_abs;
  logic                 w_off;
  logic                 w_fit;
  logic signed [DW-1:0] w_sat;

  assign o_rdy  = (r_state == ACC) && !rst;
  assign w_take = i_valid && o_rdy;
  assign w_last = (r_cnt == IW'(N - 1));

  assign w_acc_nx = r_acc + {{IW{x[DW-1]}}, x};

  // strict compare keeps the earlier element on a tie
  assign w_upd      = (r_cnt == '0) || (x > r_max);
  assign w_max_nx   = w_upd ? x : r_max;
  assign w_max_i_nx = w_upd ? x_i : r_max_i;

  assign w_seq_nx = r_seq_err | (x_i != r_cnt);
  assign w_neg_nx = r_neg_err | x[DW-1];

  assign w_dev     = {w_acc_nx[AW-1], w_acc_nx} - ((AW+1)'(1) <<< FRAC);
  assign w_dev_abs = w_dev[AW] ? -w_dev : w_dev;
  assign w_off     = w_dev_abs > (AW+1)'(TOL);

  // fits in DW when all bits above the DW sign bit match it
  assign w_fit = (&w_acc_nx[AW-1:DW-1]) || !(|w_acc_nx[AW-1:DW-1]);
  assign w_sat = w_fit ? w_acc_nx[DW-1:0]
               : (w_acc_nx[AW-1] ? {1'b1, {(DW-1){1'b0}}}
                                 : {1'b0, {(DW-1){1'b1}}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ACC;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_max     <= '0;
      r_max_i   <= '0;
      r_seq_err <= 1'b0;
      r_neg_err <= 1'b0;
      o_valid   <= 1'b0;
      y_class   <= '0;
      y_prob    <= '0;
      y_sum     <= '0;
      y_err     <= '0;
    end else begin
      case (r_state)
        ACC: begin
          if (w_take) begin
            r_cnt     <= r_cnt + 1'b1;
            r_acc     <= w_acc_nx;
            r_max     <= w_max_nx;
            r_max_i   <= w_max_i_nx;
            r_seq_err <= w_seq_nx;
            r_neg_err <= w_neg_nx;
            if (w_last) begin
              r_state <= OUT;
              o_valid <= 1'b1;
              y_class <= w_max_i_nx;
              y_prob  <= w_max_nx;
              y_sum   <= w_sat;
              y_err   <= {w_neg_nx, w_off, w_seq_nx};
            end
          end
        end
        OUT: begin
          if (i_rdy) begin
            r_state   <= ACC;
            o_valid   <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_max     <= '0;
            r_max_i   <= '0;
            r_seq_err <= 1'b0;
            r_neg_err <= 1'b0;
          end
        end
        default: r_state <= ACC;
      endcase
    end
  end

endmodule
